ddr_req_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-beat DDR control port of `avalon_mm_ddr` (`wr_rq`/`rd_rq`/`action_done`/`rd_valid`). It lets the DDR setup/preload path and the packet-generator fetch path share one DDR4 Avalon-MM channel. It grants one transaction at a time, round-robin or fixed priority. It holds address, data and byte-enables stable until the controller reports completion, and returns read data and completion only to the owning requester.

---
 rtl/ddr_req_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_ddr_req_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_req_arbiter.sv
// Two-requester arbiter/sequencer for the single-beat avalon_mm_ddr port.
// Ports: clk/rst_n, r0_*/r1_* requester sides, DDR strobes, busy/owner/timeout_err.
module ddr_req_arbiter #(
  parameter int PRIO_FIXED = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         r0_req,
  input  logic         r0_wr,
  input  logic [24:0]  r0_addr,
  input  logic [255:0] r0_wdata,
  input  logic [31:0]  r0_be,
  output logic         r0_ack,
  output logic         r0_done,
  output logic [255:0] r0_rdata,
  output logic         r0_rvalid,
  input  logic         r1_req,
  input  logic         r1_wr,
  input  logic [24:0]  r1_addr,
  input  logic [255:0] r1_wdata,
  input  logic [31:0]  r1_be,
  output logic         r1_ack,
  output logic         r1_done,
  output logic [255:0] r1_rdata,
  output logic         r1_rvalid,
  output logic         wr_rq,
  output logic         rd_rq,
  output logic [24:0]  wr_adr,
  output logic [24:0]  rd_adr,
  output logic [255:0] wr_data,
  output logic [31:0]  byte_enable,
  input  logic         rd_valid,
  input  logic [255:0] rd_data,
  input  logic         action_done,
  output logic         busy,
  output logic         owner,
  output logic         timeout_err
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t       state_q, state_d;
  logic         owner_q, owner_d;
  logic         last_q, last_d;
  logic         hwr_q, hwr_d;
  logic [24:0]  haddr_q, haddr_d;
  logic [255:0] hdata_q, hdata_d;
  logic [31:0]  hbe_q, hbe_d;
  logic [1:0]   ack_q, ack_d;
  logic [1:0]   done_q, done_d;
  logic [1:0]   rv_q, rv_d;
  logic [255:0] rd0_q, rd0_d;
  logic [255:0] rd1_q, rd1_d;
  logic         wrq_q, wrq_d;
  logic         rdq_q, rdq_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         terr_q, terr_d;

  logic         sel;
  logic         tmo_hit;
  logic [1:0]   own_vec;

  // On contention, round-robin favours whoever was not served last.
  assign sel = (r0_req && r1_req)
             ? ((PRIO_FIXED != 0) ? 1'b0 : ~last_q)
             : r1_req;

  assign tmo_hit = (cnt_q == TMO_LAST);
  assign own_vec = owner_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hwr_d   = hwr_q;
    haddr_d = haddr_q;
    hdata_d = hdata_q;
    hbe_d   = hbe_q;
    ack_d   = 2'b00;
    done_d  = 2'b00;
    rv_d    = 2'b00;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    wrq_d   = 1'b0;
    rdq_d   = 1'b0;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (r0_req || r1_req) begin
          owner_d = sel;
          last_d  = sel;
          hwr_d   = sel ? r1_wr    : r0_wr;
          haddr_d = sel ? r1_addr  : r0_addr;
          hdata_d = sel ? r1_wdata : r0_wdata;
          hbe_d   = sel ? r1_be    : r0_be;
          ack_d   = sel ? 2'b10 : 2'b01;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // First ISSUE cycle arms the strobe; the second
        // (strobe visible) hands over to WAIT.
        cnt_d = 16'd0;
        if (!(wrq_q || rdq_q)) begin
          wrq_d = hwr_q;
          rdq_d = ~hwr_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rd_valid && !hwr_q &&
            (action_done || !tmo_hit)) begin
          rv_d = own_vec;
          if (owner_q) rd1_d = rd_data;
          else         rd0_d = rd_data;
        end
        if (action_done) begin
          done_d  = own_vec;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          done_d  = own_vec;
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      hwr_q   <= 1'b0;
      haddr_q <= '0;
      hdata_q <= '0;
      hbe_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      rv_q    <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      wrq_q   <= 1'b0;
      rdq_q   <= 1'b0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hwr_q   <= hwr_d;
      haddr_q <= haddr_d;
      hdata_q <= hdata_d;
      hbe_q   <= hbe_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      wrq_q   <= wrq_d;
      rdq_q   <= rdq_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  assign r0_ack      = ack_q[0];
  assign r1_ack      = ack_q[1];
  assign r0_done     = done_q[0];
  assign r1_done     = done_q[1];
  assign r0_rvalid   = rv_q[0];
  assign r1_rvalid   = rv_q[1];
  assign r0_rdata    = rd0_q;
  assign r1_rdata    = rd1_q;
  assign wr_rq       = wrq_q;
  assign rd_rq       = rdq_q;
  assign wr_adr      = haddr_q;
  assign rd_adr      = haddr_q;
  assign wr_data     = hdata_q;
  assign byte_enable = hbe_q;
  assign busy        = (state_q != ST_IDLE);
  assign owner       = owner_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Bench for ddr_req_arbiter: two instances (round-robin TIMEOUT=8,
// fixed priority TIMEOUT=1024) checked against a transaction-age model.
module tb_ddr_req_arbiter;

  localparam logic [255:0] PAT_A = {8{32'hA5A5_0F0F}};
  localparam logic [255:0] RD_B  = {{7{32'hC0DE_0001}}, 32'h2005_BF6B};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic         rq_in   [2][2];
  logic         wr_in   [2][2];
  logic [24:0]  addr_in [2][2];
  logic [255:0] wd_in   [2][2];
  logic [31:0]  be_in   [2][2];
  logic         rv_in   [2];
  logic [255:0] rdd_in  [2];
  logic         act_in  [2];
  bit           hold    [2][2];

  logic         ack_o   [2][2];
  logic         done_o  [2][2];
  logic         rvo_o   [2][2];
  logic [255:0] rdata_o [2][2];
  logic         wr_rq_o [2];
  logic         rd_rq_o [2];
  logic [24:0]  wadr_o  [2];
  logic [24:0]  radr_o  [2];
  logic [255:0] wdat_o  [2];
  logic [31:0]  be_o    [2];
  logic         busy_o  [2];
  logic         owner_o [2];
  logic         terr_o  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ddr_req_arbiter #(
      .PRIO_FIXED(g),
      .TIMEOUT((g == 0) ? 8 : 1024)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .r0_req(rq_in[g][0]),
      .r0_wr(wr_in[g][0]),
      .r0_addr(addr_in[g][0]),
      .r0_wdata(wd_in[g][0]),
      .r0_be(be_in[g][0]),
      .r0_ack(ack_o[g][0]),
      .r0_done(done_o[g][0]),
      .r0_rdata(rdata_o[g][0]),
      .r0_rvalid(rvo_o[g][0]),
      .r1_req(rq_in[g][1]),
      .r1_wr(wr_in[g][1]),
      .r1_addr(addr_in[g][1]),
      .r1_wdata(wd_in[g][1]),
      .r1_be(be_in[g][1]),
      .r1_ack(ack_o[g][1]),
      .r1_done(done_o[g][1]),
      .r1_rdata(rdata_o[g][1]),
      .r1_rvalid(rvo_o[g][1]),
      .wr_rq(wr_rq_o[g]),
      .rd_rq(rd_rq_o[g]),
      .wr_adr(wadr_o[g]),
      .rd_adr(radr_o[g]),
      .wr_data(wdat_o[g]),
      .byte_enable(be_o[g]),
      .rd_valid(rv_in[g]),
      .rd_data(rdd_in[g]),
      .action_done(act_in[g]),
      .busy(busy_o[g]),
      .owner(owner_o[g]),
      .timeout_err(terr_o[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [511:0] a,
                     input logic [511:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  // ---------------- model ----------------
  int tmo_of [2] = '{8, 1024};
  bit prio_of[2] = '{1'b0, 1'b1};

  bit           s_rst;
  logic         s_req [2][2];
  logic         s_wr  [2][2];
  logic [24:0]  s_addr[2][2];
  logic [255:0] s_wd  [2][2];
  logic [31:0]  s_be  [2][2];
  logic         s_rv  [2];
  logic [255:0] s_rdd [2];
  logic         s_act [2];

  bit           m_busy [2];
  int           m_age  [2];
  bit           m_wr   [2];
  logic [24:0]  m_addr [2];
  logic [255:0] m_data [2];
  logic [31:0]  m_be   [2];
  bit           m_own  [2];
  bit           m_last [2];
  bit           m_terr [2];
  logic [255:0] m_rdata[2][2];
  bit           m_ack  [2][2];
  bit           m_done [2][2];
  bit           m_rv   [2][2];
  bit           m_wrq  [2];
  bit           m_rrq  [2];

  // m_age: 1 = ack cycle, 2 = strobe cycle, >=3 = waiting (age-3 waited).
  task automatic model_step(input int k);
    int w;
    bit fin;
    for (int r = 0; r < 2; r++) begin
      m_ack[k][r] = 0;
      m_done[k][r] = 0;
      m_rv[k][r] = 0;
    end
    m_wrq[k] = 0;
    m_rrq[k] = 0;
    if (!s_rst) begin
      m_busy[k] = 0; m_age[k] = 0;
      m_own[k] = 0; m_last[k] = 1;
      m_wr[k] = 0; m_addr[k] = '0;
      m_data[k] = '0; m_be[k] = '0;
      m_terr[k] = 0;
      m_rdata[k][0] = '0;
      m_rdata[k][1] = '0;
    end else if (!m_busy[k]) begin
      if (s_req[k][0] || s_req[k][1]) begin
        if (s_req[k][0] && s_req[k][1])
          w = prio_of[k] ? 0 : (m_last[k] ? 0 : 1);
        else
          w = s_req[k][1] ? 1 : 0;
        m_wr[k] = s_wr[k][w];
        m_addr[k] = s_addr[k][w];
        m_data[k] = s_wd[k][w];
        m_be[k] = s_be[k][w];
        m_own[k] = (w == 1);
        m_last[k] = (w == 1);
        m_ack[k][w] = 1;
        m_busy[k] = 1;
        m_age[k] = 1;
      end
    end else if (m_age[k] == 1) begin
      m_wrq[k] = m_wr[k];
      m_rrq[k] = !m_wr[k];
      m_age[k] = 2;
    end else if (m_age[k] == 2) begin
      m_age[k] = 3;
    end else begin
      fin = (m_age[k] - 3 == tmo_of[k] - 1);
      if (s_rv[k] && !m_wr[k] && (s_act[k] || !fin)) begin
        m_rdata[k][m_own[k]] = s_rdd[k];
        m_rv[k][m_own[k]] = 1;
      end
      if (s_act[k] || fin) begin
        m_done[k][m_own[k]] = 1;
        m_busy[k] = 0;
        if (!s_act[k]) m_terr[k] = 1;
      end else begin
        m_age[k]++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      s_rst = rst_n;
      s_req = rq_in;   s_wr = wr_in;
      s_addr = addr_in; s_wd = wd_in;
      s_be = be_in;    s_rv = rv_in;
      s_rdd = rdd_in;  s_act = act_in;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        model_step(k);
        chk($sformatf("ctl%0d", k),
          {ack_o[k][1], ack_o[k][0], done_o[k][1], done_o[k][0],
           rvo_o[k][1], rvo_o[k][0], wr_rq_o[k], rd_rq_o[k],
           busy_o[k], owner_o[k], terr_o[k]},
          {m_ack[k][1], m_ack[k][0], m_done[k][1], m_done[k][0],
           m_rv[k][1], m_rv[k][0], m_wrq[k], m_rrq[k],
           m_busy[k], m_own[k], m_terr[k]});
        chk($sformatf("adr_be%0d", k),
          {wadr_o[k], radr_o[k], be_o[k]},
          {m_addr[k], m_addr[k], m_be[k]});
        chk($sformatf("wdata%0d", k), wdat_o[k], m_data[k]);
        chk($sformatf("rdata0_%0d", k), rdata_o[k][0], m_rdata[k][0]);
        chk($sformatf("rdata1_%0d", k), rdata_o[k][1], m_rdata[k][1]);
      end
    end
  end

  // Requesters drop req once acked unless told to keep requesting.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < 2; r++)
          if (ack_o[k][r] === 1'b1 && !hold[k][r]) rq_in[k][r] = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int k, output int who);
    bit ok = 0;
    who = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ack_o[k][0] === 1'b1 || ack_o[k][1] === 1'b1) begin
        ok = 1;
        who = (ack_o[k][1] === 1'b1) ? 1 : 0;
        break;
      end
    end
    if (!ok) chk("ack_wait_expired", 0, 1);
  endtask

  task automatic wait_rq(input int k);
    bit ok = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (wr_rq_o[k] === 1'b1 || rd_rq_o[k] === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("rq_wait_expired", 0, 1);
  endtask

  task automatic pulse_act(input int k, input bit rv,
                           input logic [255:0] d);
    act_in[k] = 1'b1;
    rv_in[k] = rv;
    rdd_in[k] = d;
    tick();
    act_in[k] = 1'b0;
    rv_in[k] = 1'b0;
  endtask

  task automatic respond(input int k, input int dly, input bit rv,
                         input logic [255:0] d, output int who);
    wait_ack(k, who);
    wait_rq(k);
    repeat (dly) tick();
    pulse_act(k, rv, d);
  endtask

  // ---------------- directed tests ----------------
  int who;
  int lat;
  int got[6];
  int exp_rr[6] = '{0, 1, 0, 1, 0, 1};
  int exp_fx[4] = '{0, 0, 0, 1};

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 2; r++) begin
        rq_in[k][r] = 0; wr_in[k][r] = 0;
        addr_in[k][r] = '0; wd_in[k][r] = '0;
        be_in[k][r] = '0; hold[k][r] = 0;
      end
      rv_in[k] = 0; rdd_in[k] = '0; act_in[k] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_owner", owner_o[0], 0);
    chk("rst_busy", busy_o[0], 0);

    // single write from r0, action_done 3 cycles after wr_rq
    wr_in[0][0] = 1; addr_in[0][0] = 25'h40;
    wd_in[0][0] = PAT_A; be_in[0][0] = 32'hFFFF_FFFF;
    rq_in[0][0] = 1;
    tick();
    chk("t1_ack_r0", ack_o[0][0], 1);
    chk("t1_ack_r1", ack_o[0][1], 0);
    tick();
    chk("t1_wr_rq", wr_rq_o[0], 1);
    chk("t1_wr_adr", wadr_o[0], 25'h40);
    tick();
    chk("t1_wr_rq_once", wr_rq_o[0], 0);
    tick();
    tick();
    pulse_act(0, 0, '0);
    chk("t1_done", done_o[0][0], 1);
    chk("t1_r1_quiet", done_o[0][1], 0);

    // read from r1, rd_valid together with action_done
    wr_in[0][1] = 0; addr_in[0][1] = 25'h14CC;
    be_in[0][1] = 32'hFFFF_FFFF; rq_in[0][1] = 1;
    respond(0, 2, 1, RD_B, who);
    chk("t2_who", who, 1);
    chk("t2_rvalid", rvo_o[0][1], 1);
    chk("t2_done", done_o[0][1], 1);
    chk("t2_rdata", rdata_o[0][1], RD_B);

    // write from r0 with a stray rd_valid
    wr_in[0][0] = 1; addr_in[0][0] = 25'h123;
    wd_in[0][0] = ~PAT_A; be_in[0][0] = 32'h0000_FFFF;
    rq_in[0][0] = 1;
    wait_ack(0, who);
    wait_rq(0);
    tick();
    rv_in[0] = 1; rdd_in[0] = {8{32'hDEAD_BEEF}};
    tick();
    rv_in[0] = 0;
    chk("t6_no_rvalid", rvo_o[0][0], 0);
    pulse_act(0, 0, '0);
    chk("t6_done", done_o[0][0], 1);
    chk("t6_rdata_kept", rdata_o[0][0], 0);

    // timeout: read from r0, no action_done
    wr_in[0][0] = 0; addr_in[0][0] = 25'h777;
    rq_in[0][0] = 1;
    wait_ack(0, who);
    wait_rq(0);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done_o[0][0] === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk("t4_latency", lat, 9);
    chk("t4_terr", terr_o[0], 1);
    repeat (2) tick();
    pulse_act(0, 1, {8{32'h1234_5678}});
    repeat (3) tick();
    chk("t4_terr_sticky", terr_o[0], 1);
    chk("t4_rdata_kept", rdata_o[0][0], 0);

    // reset in the middle of a WAIT
    wr_in[0][1] = 1; addr_in[0][1] = 25'h55;
    wd_in[0][1] = PAT_A; rq_in[0][1] = 1;
    wait_ack(0, who);
    wait_rq(0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("t5_no_done", done_o[0][1], 0);
    chk("t5_busy", busy_o[0], 0);
    chk("t5_rdata1", rdata_o[0][1], 0);
    chk("t5_terr", terr_o[0], 0);

    // both requesting continuously, round-robin
    rst_n = 1'b1;
    hold[0][0] = 1; hold[0][1] = 1;
    wr_in[0][0] = 1; addr_in[0][0] = 25'h100;
    wr_in[0][1] = 0; addr_in[0][1] = 25'h200;
    rq_in[0][0] = 1; rq_in[0][1] = 1;
    for (int i = 0; i < 6; i++) begin
      respond(0, 1, 1, {8{32'(i + 1)}}, who);
      got[i] = who;
    end
    rq_in[0][0] = 0; rq_in[0][1] = 0;
    hold[0][0] = 0; hold[0][1] = 0;
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order%0d", i), got[i], exp_rr[i]);

    // fixed priority: r0 keeps winning until it drops req
    hold[1][0] = 1; hold[1][1] = 1;
    wr_in[1][0] = 1; addr_in[1][0] = 25'h10;
    wr_in[1][1] = 1; addr_in[1][1] = 25'h20;
    rq_in[1][0] = 1; rq_in[1][1] = 1;
    for (int i = 0; i < 3; i++) begin
      respond(1, 2, 0, '0, who);
      got[i] = who;
    end
    rq_in[1][0] = 0; hold[1][0] = 0;
    respond(1, 1, 0, '0, who);
    got[3] = who;
    rq_in[1][1] = 0; hold[1][1] = 0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("fx_order%0d", i), got[i], exp_fx[i]);

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
